// File: rtl/key_expand_dec_if.sv
// Request/response bundle between the key loader side and the AES-128 round-key store.
interface key_expand_dec_if;
    logic [127:0] key_in;
    logic         key_valid;
    logic [3:0]   rk_sel;
    logic [127:0] rk_out;
    logic         busy;
    logic         done;

    modport master (output key_in, output key_valid, output rk_sel,
                    input  rk_out, input  busy,      input  done);
    modport slave  (input  key_in, input  key_valid, input  rk_sel,
                    output rk_out, output busy,      output done);
endinterface

// File: rtl/key_expand_dec.sv
// AES-128 key schedule: expands one cipher key into round keys 0..10, one per clock,
// and serves them by index (registered read) to the decryption datapath.
module key_expand_dec #(
    parameter int NR = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    key_expand_dec_if.slave bus
);

    if (NR != 10) begin : g_bad_nr
        $error("key_expand_dec supports only NR = 10 (AES-128)");
    end

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [1:0]   state;
    logic [3:0]   cnt;
    logic [127:0] rk [0:10];
    logic [127:0] rk_out_q;

    logic [3:0]   prev_idx;
    logic [127:0] prev_rk;
    logic [31:0]  temp, nw0, nw1, nw2, nw3;

    // One round of the schedule, always derived from the entry written on the previous edge.
    always_comb begin
        prev_idx = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
        prev_rk  = rk[prev_idx];
        temp = {SBOX[prev_rk[23:16]], SBOX[prev_rk[15:8]], SBOX[prev_rk[7:0]], SBOX[prev_rk[31:24]]}
               ^ {rcon(cnt), 24'h0};
        nw0 = prev_rk[127:96] ^ temp;
        nw1 = prev_rk[95:64]  ^ nw0;
        nw2 = prev_rk[63:32]  ^ nw1;
        nw3 = prev_rk[31:0]   ^ nw2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            for (int unsigned i = 0; i <= 10; i++) begin
                rk[i] <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.key_valid) begin
                        rk[0] <= bus.key_in;
                        cnt   <= 4'd1;
                        state <= EXPAND;
                    end
                end
                EXPAND: begin
                    rk[cnt] <= {nw0, nw1, nw2, nw3};
                    cnt     <= cnt + 4'd1;
                    if (cnt == 4'd10) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read port runs every cycle regardless of FSM state; indices past 10 read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_out_q <= '0;
        end else if (bus.rk_sel <= 4'd10) begin
            rk_out_q <= rk[bus.rk_sel];
        end else begin
            rk_out_q <= '0;
        end
    end

    assign bus.rk_out = rk_out_q;
    assign bus.busy   = (state == EXPAND);
    assign bus.done   = (state == DONE);

endmodule

// File: tb/tb_key_expand_dec.sv
// Self-checking bench for key_expand_dec; reference schedule is built from GF(2^8) arithmetic.
module tb_key_expand_dec;

    logic clk;
    logic rst_n;
    key_expand_dec_if bus ();

    key_expand_dec #(.NR(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    logic [7:0]   sb [0:255];
    logic [127:0] exp_rk [0:10];

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_math(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        logic [7:0] c   = 8'h63;
        logic [7:0] o;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        for (int i = 0; i < 8; i++)
            o[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
        return o;
    endfunction

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic start_key(input logic [127:0] k);
        bus.key_in    = k;
        bus.key_valid = 1'b1;
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
    endtask

    task automatic wait_done(output int n, output int bc);
        n = 0; bc = 0;
        while (!bus.done && n < 40) begin
            if (bus.busy) bc++;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic read_rk(input logic [3:0] s, output logic [127:0] v);
        bus.rk_sel = s;
        @(posedge clk); #1;
        v = bus.rk_out;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_in = '0;
        bus.rk_sel = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.rk_out !== 128'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: rk_out=%h busy=%b done=%b, required 0/0/0", bus.rk_out, bus.busy, bus.done);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.rk_sel = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
            vectors++;
            if (bus.rk_out !== 128'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_hold c%0d: rk_out=%h busy=%b done=%b, required 0/0/0", c, bus.rk_out, bus.busy, bus.done);
            end
        end
    endtask

    task automatic test_fips;
        logic [127:0] k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        logic [127:0] v;
        int n, bc;
        model_expand(k);
        start_key(k);
        wait_done(n, bc);
        vectors++;
        if (n !== 10 || bc !== 10 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL fips_timing: edges=%0d busy_cycles=%0d done=%b busy=%b, required 10/10/1/0", n, bc, bus.done, bus.busy);
        end
        read_rk(4'd1, v);
        vectors++;
        if (v !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            miscompares++;
            $display("FAIL fips_rk1: got %h, required a0fafe1788542cb123a339392a6c7605", v);
        end
        read_rk(4'd10, v);
        vectors++;
        if (v !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            miscompares++;
            $display("FAIL fips_rk10: got %h, required d014f9a8c9ee2589e13f0cc8b6630ca6", v);
        end
        read_rk(4'd0, v);
        vectors++;
        if (v !== k) begin
            miscompares++;
            $display("FAIL fips_rk0: got %h, required %h", v, k);
        end
    endtask

    task automatic test_reverse_read;
        bus.rk_sel = 4'd10;
        for (int s = 10; s >= 0; s--) begin
            @(posedge clk); #1;
            vectors++;
            if (bus.rk_out !== exp_rk[s]) begin
                miscompares++;
                $display("FAIL reverse_rk%0d: got %h, required %h", s, bus.rk_out, exp_rk[s]);
            end
            if (s > 0) bus.rk_sel = 4'(s - 1);
        end
    endtask

    task automatic test_out_of_range;
        logic [127:0] v;
        logic [3:0] sels [0:3];
        sels[0] = 4'd11; sels[1] = 4'd15;
        sels[2] = 4'($urandom_range(11, 15)); sels[3] = 4'($urandom_range(11, 15));
        for (int i = 0; i < 4; i++) begin
            read_rk(4'd10, v);
            read_rk(sels[i], v);
            vectors++;
            if (v !== 128'h0) begin
                miscompares++;
                $display("FAIL oob_sel%0d: got %h, required 0", sels[i], v);
            end
        end
    endtask

    task automatic test_ignored_strobe;
        logic [127:0] ka = {$urandom, $urandom, $urandom, $urandom};
        logic [127:0] kb = ~ka;
        logic [127:0] v;
        int n = 0;
        model_expand(ka);
        start_key(ka);
        while (!bus.done && n < 40) begin
            if (n == 3) begin
                bus.key_in = kb;
                bus.key_valid = 1'b1;
            end else begin
                bus.key_valid = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        bus.key_valid = 1'b0;
        vectors++;
        if (n !== 10) begin
            miscompares++;
            $display("FAIL ignored_strobe_timing: edges=%0d, required 10", n);
        end
        for (int r = 0; r <= 10; r++) begin
            read_rk(4'(r), v);
            vectors++;
            if (v !== exp_rk[r]) begin
                miscompares++;
                $display("FAIL ignored_strobe_rk%0d: got %h, required %h", r, v, exp_rk[r]);
            end
        end
    endtask

    task automatic test_restart;
        logic [127:0] k = 128'h000102030405060708090a0b0c0d0e0f;
        logic [127:0] v;
        int n, bc;
        model_expand(k);
        start_key(k);
        vectors++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_edge: done=%b busy=%b, required 0/1", bus.done, bus.busy);
        end
        wait_done(n, bc);
        vectors++;
        if (n !== 10 || bc !== 10) begin
            miscompares++;
            $display("FAIL restart_timing: edges=%0d busy_cycles=%0d, required 10/10", n, bc);
        end
        read_rk(4'd10, v);
        vectors++;
        if (v !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
            miscompares++;
            $display("FAIL restart_rk10: got %h, required 13111d7fe3944a17f307a78b4d2b30c5", v);
        end
        for (int r = 0; r < 10; r++) begin
            read_rk(4'(r), v);
            vectors++;
            if (v !== exp_rk[r]) begin
                miscompares++;
                $display("FAIL restart_rk%0d: got %h, required %h", r, v, exp_rk[r]);
            end
        end
    endtask

    task automatic test_random_keys;
        logic [127:0] k, v;
        int n, bc, r;
        for (int t = 0; t < 6; t++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            model_expand(k);
            start_key(k);
            wait_done(n, bc);
            vectors++;
            if (n !== 10 || bc !== 10) begin
                miscompares++;
                $display("FAIL rand%0d_timing: edges=%0d busy_cycles=%0d, required 10/10", t, n, bc);
            end
            for (int i = 0; i < 8; i++) begin
                r = $urandom_range(0, 10);
                read_rk(4'(r), v);
                vectors++;
                if (v !== exp_rk[r]) begin
                    miscompares++;
                    $display("FAIL rand%0d_rk%0d: got %h, required %h", t, r, v, exp_rk[r]);
                end
            end
        end
    endtask

    task automatic test_midop_reset;
        logic [127:0] v;
        bus.rk_sel = 4'd0;
        start_key({$urandom, $urandom, $urandom, $urandom});
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.rk_out !== 128'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_reset: rk_out=%h busy=%b done=%b, required 0/0/0", bus.rk_out, bus.busy, bus.done);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int r = 0; r <= 10; r++) begin
            read_rk(4'(r), v);
            vectors++;
            if (v !== 128'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                miscompares++;
                $display("FAIL midop_cleared_rk%0d: got %h busy=%b done=%b, required 0/0/0", r, v, bus.busy, bus.done);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 256; i++) sb[i] = sbox_math(8'(i));
        test_reset;
        test_fips;
        test_reverse_read;
        test_out_of_range;
        test_ignored_strobe;
        test_restart;
        test_random_keys;
        test_midop_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
